mem1_arbiter: RTL and testbench
===============================

Name: mem1_arbiter

Overview:
- Arbitrates the single-port sample memory (mem1) between two requesters: the whitening unit (burst writes of whitened samples) and the FastICA core (burst reads for each iteration).
- Sits between the main controller's memory interface and the mem1 macro, and replaces direct rw/address muxing by the controller.
- Burst-oriented, with round-robin arbitration on conflict and a fixed memory read latency.

Parameters:
- DW, 16, data width of the mem1 word.
- AW, 14, address width (matches address_sel_mem1).
- DEPTH, 16384, number of mem1 words; address wraps from DEPTH-1 to 0.
- LW, 8, burst length field width.
- RD_LAT, 1, mem1 read latency in cycles (1..4).

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- wr_req  in  1  whitening burst request; held high until wr_gnt.
- wr_addr  in  AW  write burst start address; latched at grant.
- wr_len  in  LW  write burst length minus 1; latched at grant.
- wr_data  in  DW  write data for the current beat.
- wr_gnt  out  1  one-cycle pulse on the first write beat.
- wr_beat  out  1  high on every cycle where wr_data is consumed.
- wr_done  out  1  one-cycle pulse in the cycle after the last write beat.
- rd_req  in  1  FastICA burst request; held high until rd_gnt.
- rd_addr  in  AW  read burst start address.
- rd_len  in  LW  read burst length minus 1.
- rd_gnt  out  1  one-cycle pulse on the first read issue cycle.
- rd_data  out  DW  read data, valid when rd_valid is high.
- rd_valid  out  1  read data strobe.
- rd_done  out  1  pulse coincident with the last rd_valid.
- mem_en  out  1  mem1 access enable.
- mem_rw  out  1  1 = write, 0 = read.
- mem_addr  out  AW  mem1 address.
- mem_wdata  out  DW  mem1 write data (combinational from wr_data).
- mem_rdata  in  DW  mem1 read data, RD_LAT cycles after the read issue.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - Every output is 0, with rd_data = 0.
  - State = IDLE; last_owner = RD, so write wins the first conflict.
  - Counters are cleared.
- FSM states: IDLE, WR_BURST, RD_BURST, RD_DRAIN.
- IDLE:
  - Requests are sampled only in IDLE.
  - wr_req only: next state WR_BURST.
  - rd_req only: next state RD_BURST.
  - Both requests: the side that is not last_owner wins; last_owner updates on each grant.
  - The latched address and length are taken in the same cycle.
- Grant latency: a request at cycle t gives grant plus first beat at t+1. gnt is Moore-style, high only in the first burst cycle.
- WR_BURST:
  - mem_en = 1, mem_rw = 1, wr_beat = 1 every cycle.
  - Occupies exactly len+1 cycles; len = 0 gives 1 beat, len = 255 gives 256 beats.
  - After the last beat: go to IDLE and pulse wr_done.
- RD_BURST:
  - mem_en = 1, mem_rw = 0 for len+1 cycles.
  - Then go to RD_DRAIN for RD_LAT cycles; mem_en = 0 while draining.
  - Then go to IDLE.
- Read return:
  - rd_valid is a delayed copy of the read issue strobe, delayed by RD_LAT cycles; rd_data = mem_rdata when rd_valid is high.
  - rd_done coincides with the last rd_valid.
- Addressing:
  - mem_addr = latched start address plus beat index, modulo DEPTH.
  - Wrap from DEPTH-1 to 0 inside a burst is legal and silent.
- Bus gap: at least one IDLE cycle between consecutive bursts.
- Idle bus state: in IDLE, mem_en = 0 and mem_addr holds its last value.
- Request changes during a burst:
  - Deasserting req during a burst is ignored; the burst completes.
  - New requests wait for IDLE.
- Mid-burst reset: rst mid-burst abandons the burst immediately. No done pulse, and in-flight rd_valid is suppressed.
- Illegal conditions (none reached through the ports):
  - An unknown state returns to IDLE.
  - Beat counter arithmetic is LW+1 bits wide to avoid overflow at len = 2^LW-1.

Optional Feature:
- Macro: MEM1_ARB_STATS_EN.
- Defined: adds outputs stat_wr_bursts[15:0], stat_rd_bursts[15:0] and stat_conflicts[15:0].
  - stat_wr_bursts and stat_rd_bursts count grants.
  - stat_conflicts counts IDLE cycles with both requests high.
  - All three saturate at 16'hFFFF and are cleared by rst.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fastica_mem_pkg holds:
  - the ARB_STATE enum;
  - the OWNER_WR/OWNER_RD constants;
  - MEM_RW_WRITE = 1 and MEM_RW_READ = 0;
  - default AW/DW constants.
- Sub-module mem1_addr_gen:
  - loads start address and length;
  - increments with wrap at DEPTH;
  - flags the last beat.
- The arbiter instantiates one mem1_addr_gen, shared by both bursts.

Test Plan:
- Single write: rst, then wr_req with addr 0x0010, len 3 -> wr_gnt at t+1; mem_addr 0x10..0x13 with mem_rw = 1 over 4 cycles; wr_done at t+5.
- Single read, RD_LAT = 2: rd_req with addr 0x0100, len 0 -> one read issue at t+1; rd_valid and rd_done at t+3 with rd_data = mem_rdata.
- Conflict round-robin:
  - First simultaneous request: write granted first, then read.
  - Second simultaneous request: read granted first.
  - With stats enabled, stat_conflicts = 2.
- Address wrap: write with addr 0x3FFE, len 3 -> mem_addr sequence 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- Reset mid-burst: assert rst on the 3rd beat of a len 7 read -> next cycle all outputs 0, no rd_done, no further rd_valid.
- Maximum length: write len 255 -> exactly 256 wr_beat cycles, wr_done once, busy low in the following cycle.

Source files
------------

// File: rtl/fastica_mem_pkg.sv
// rtl/fastica_mem_pkg.sv - shared types and constants for the mem1 arbiter slice
package fastica_mem_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2,
        RD_DRAIN = 2'd3
    } arb_state_t;

    localparam logic OWNER_WR     = 1'b0;
    localparam logic OWNER_RD     = 1'b1;

    localparam logic MEM_RW_WRITE = 1'b1;
    localparam logic MEM_RW_READ  = 1'b0;

    localparam int DEF_DW    = 16;
    localparam int DEF_AW    = 14;
    localparam int DEF_LW    = 8;
    localparam int DEF_DEPTH = 16384;

endpackage

// File: rtl/mem1_arbiter_if.sv
// rtl/mem1_arbiter_if.sv - requester, read-return and mem1 macro signals of the mem1 arbiter
interface mem1_arbiter_if #(
    parameter int DW = fastica_mem_pkg::DEF_DW,
    parameter int AW = fastica_mem_pkg::DEF_AW,
    parameter int LW = fastica_mem_pkg::DEF_LW
) ();

    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [LW-1:0] wr_len;
    logic [DW-1:0] wr_data;
    logic          wr_gnt;
    logic          wr_beat;
    logic          wr_done;

    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [LW-1:0] rd_len;
    logic          rd_gnt;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_done;

    logic          mem_en;
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport master (
        output wr_req, wr_addr, wr_len, wr_data, rd_req, rd_addr, rd_len, mem_rdata,
        input  wr_gnt, wr_beat, wr_done, rd_gnt, rd_data, rd_valid, rd_done,
               mem_en, mem_rw, mem_addr, mem_wdata, busy
    );

    modport slave (
        input  wr_req, wr_addr, wr_len, wr_data, rd_req, rd_addr, rd_len, mem_rdata,
        output wr_gnt, wr_beat, wr_done, rd_gnt, rd_data, rd_valid, rd_done,
               mem_en, mem_rw, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/mem1_addr_gen.sv
// rtl/mem1_addr_gen.sv - burst address/beat counter shared by write and read bursts
module mem1_addr_gen
    import fastica_mem_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int LW    = DEF_LW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [AW-1:0] i_start_addr,
    input  logic [LW-1:0] i_len,
    input  logic          i_advance,
    output logic [AW-1:0] o_addr,
    output logic          o_last
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [AW-1:0] r_addr;
    logic [LW:0]   r_cnt;
    logic [LW-1:0] r_len;

    // Counter is one bit wider than len so len = 2^LW-1 still terminates
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_cnt  <= '0;
            r_len  <= '0;
        end else if (i_load) begin
            r_addr <= i_start_addr;
            r_cnt  <= '0;
            r_len  <= i_len;
        end else if (i_advance) begin
            r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + AW'(1);
            r_cnt  <= r_cnt + (LW+1)'(1);
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_cnt == {1'b0, r_len});

endmodule

// File: rtl/mem1_arbiter.sv
// rtl/mem1_arbiter.sv - round-robin burst arbiter for mem1 (whitening writes, FastICA reads)
// Define MEM1_ARB_STATS_EN to add saturating grant/conflict counters.
module mem1_arbiter
    import fastica_mem_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int AW     = DEF_AW,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int LW     = DEF_LW,
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    mem1_arbiter_if.slave bus
`ifdef MEM1_ARB_STATS_EN
    ,
    output logic [15:0] stat_wr_bursts,
    output logic [15:0] stat_rd_bursts,
    output logic [15:0] stat_conflicts
`endif
);

    arb_state_t        r_state;
    logic              r_last_owner;
    logic              r_wr_gnt;
    logic              r_wr_beat;
    logic              r_wr_done;
    logic              r_rd_gnt;
    logic              r_rd_issue;
    logic              r_mem_en;
    logic              r_mem_rw;
    logic [2:0]        r_drain;
    logic [RD_LAT-1:0] r_vld_dly;
    logic [RD_LAT-1:0] r_last_dly;

    logic              w_idle;
    logic              w_grant_wr;
    logic              w_grant_rd;
    logic              w_load;
    logic              w_advance;
    logic              w_last;
    logic [AW-1:0]     w_start_addr;
    logic [LW-1:0]     w_start_len;
    logic [AW-1:0]     w_mem_addr;
    logic [DW-1:0]     w_rdata;

    assign w_idle       = (r_state == IDLE);
    assign w_grant_wr   = w_idle & bus.wr_req & (~bus.rd_req | (r_last_owner == OWNER_RD));
    assign w_grant_rd   = w_idle & bus.rd_req & ~w_grant_wr;
    assign w_load       = w_grant_wr | w_grant_rd;
    assign w_start_addr = w_grant_wr ? bus.wr_addr : bus.rd_addr;
    assign w_start_len  = w_grant_wr ? bus.wr_len  : bus.rd_len;
    assign w_advance    = ((r_state == WR_BURST) | (r_state == RD_BURST)) & ~w_last;

    mem1_addr_gen #(
        .AW    (AW),
        .LW    (LW),
        .DEPTH (DEPTH)
    ) u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_start_addr (w_start_addr),
        .i_len        (w_start_len),
        .i_advance    (w_advance),
        .o_addr       (w_mem_addr),
        .o_last       (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_owner <= OWNER_RD;
            r_wr_gnt     <= 1'b0;
            r_wr_beat    <= 1'b0;
            r_wr_done    <= 1'b0;
            r_rd_gnt     <= 1'b0;
            r_rd_issue   <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_rw     <= MEM_RW_READ;
            r_drain      <= '0;
        end else begin
            r_wr_gnt  <= 1'b0;
            r_rd_gnt  <= 1'b0;
            r_wr_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_wr) begin
                        r_state      <= WR_BURST;
                        r_last_owner <= OWNER_WR;
                        r_wr_gnt     <= 1'b1;
                        r_wr_beat    <= 1'b1;
                        r_mem_en     <= 1'b1;
                        r_mem_rw     <= MEM_RW_WRITE;
                    end else if (w_grant_rd) begin
                        r_state      <= RD_BURST;
                        r_last_owner <= OWNER_RD;
                        r_rd_gnt     <= 1'b1;
                        r_rd_issue   <= 1'b1;
                        r_mem_en     <= 1'b1;
                        r_mem_rw     <= MEM_RW_READ;
                    end
                end
                WR_BURST: begin
                    if (w_last) begin
                        r_state   <= IDLE;
                        r_wr_beat <= 1'b0;
                        r_mem_en  <= 1'b0;
                        r_mem_rw  <= MEM_RW_READ;
                        r_wr_done <= 1'b1;
                    end
                end
                RD_BURST: begin
                    if (w_last) begin
                        r_state    <= RD_DRAIN;
                        r_rd_issue <= 1'b0;
                        r_mem_en   <= 1'b0;
                        r_drain    <= '0;
                    end
                end
                RD_DRAIN: begin
                    // Hold the bus until the last read returns
                    if (r_drain == 3'(RD_LAT - 1)) begin
                        r_state <= IDLE;
                    end else begin
                        r_drain <= r_drain + 3'd1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_wr_beat  <= 1'b0;
                    r_rd_issue <= 1'b0;
                    r_mem_en   <= 1'b0;
                    r_mem_rw   <= MEM_RW_READ;
                end
            endcase
        end
    end

    // Read-return strobes follow the issue strobe by the macro latency
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_dly  <= '0;
            r_last_dly <= '0;
        end else begin
            r_vld_dly[0]  <= r_rd_issue;
            r_last_dly[0] <= r_rd_issue & w_last;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_dly[i]  <= r_vld_dly[i-1];
                r_last_dly[i] <= r_last_dly[i-1];
            end
        end
    end

    assign w_rdata       = bus.mem_rdata;
    assign bus.rd_valid  = r_vld_dly[RD_LAT-1];
    assign bus.rd_done   = r_last_dly[RD_LAT-1];
    assign bus.rd_data   = r_vld_dly[RD_LAT-1] ? w_rdata : '0;

    assign bus.wr_gnt    = r_wr_gnt;
    assign bus.wr_beat   = r_wr_beat;
    assign bus.wr_done   = r_wr_done;
    assign bus.rd_gnt    = r_rd_gnt;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_rw    = r_mem_rw;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = bus.wr_data;
    assign bus.busy      = ~w_idle;

`ifdef MEM1_ARB_STATS_EN
    logic [15:0] r_stat_wr;
    logic [15:0] r_stat_rd;
    logic [15:0] r_stat_conf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_wr   <= '0;
            r_stat_rd   <= '0;
            r_stat_conf <= '0;
        end else begin
            if (w_grant_wr && r_stat_wr != 16'hFFFF) begin
                r_stat_wr <= r_stat_wr + 16'd1;
            end
            if (w_grant_rd && r_stat_rd != 16'hFFFF) begin
                r_stat_rd <= r_stat_rd + 16'd1;
            end
            if (w_idle && bus.wr_req && bus.rd_req && r_stat_conf != 16'hFFFF) begin
                r_stat_conf <= r_stat_conf + 16'd1;
            end
        end
    end

    assign stat_wr_bursts = r_stat_wr;
    assign stat_rd_bursts = r_stat_rd;
    assign stat_conflicts = r_stat_conf;
`endif

endmodule

// File: tb/tb_mem1_arbiter.sv
// tb/tb_mem1_arbiter.sv - scoreboard bench for mem1_arbiter (RD_LAT = 2)
module tb_mem1_arbiter;

    localparam int DW     = 16;
    localparam int AW     = 14;
    localparam int LW     = 8;
    localparam int DEPTH  = 16384;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem1_arbiter_if #(.DW(DW), .AW(AW), .LW(LW)) bus ();

`ifdef MEM1_ARB_STATS_EN
    logic [15:0] stat_wr_bursts;
    logic [15:0] stat_rd_bursts;
    logic [15:0] stat_conflicts;
`endif

    mem1_arbiter #(
        .DW     (DW),
        .AW     (AW),
        .DEPTH  (DEPTH),
        .LW     (LW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MEM1_ARB_STATS_EN
        ,
        .stat_wr_bursts (stat_wr_bursts),
        .stat_rd_bursts (stat_rd_bursts),
        .stat_conflicts (stat_conflicts)
`endif
    );

    function automatic logic [DW-1:0] init_val(input int a);
        return 16'hC000 ^ 16'(a);
    endfunction

    function automatic logic [DW-1:0] data_of(input int c);
        return 16'((c * 37) ^ 32'h3C5A);
    endfunction

    // mem1 macro stand-in: registered read with two-cycle latency
    logic [DW-1:0] mem_arr [DEPTH];
    logic          env_ready = 1'b0;
    logic [DW-1:0] rpipe0 = '0;
    logic [DW-1:0] rpipe1 = '0;

    always @(posedge clk) begin
        if (!env_ready) begin
            for (int i = 0; i < DEPTH; i++) mem_arr[i] <= init_val(i);
            env_ready <= 1'b1;
        end else if (bus.mem_en && bus.mem_rw) begin
            mem_arr[bus.mem_addr] <= bus.mem_wdata;
        end
        rpipe0 <= (bus.mem_en && !bus.mem_rw) ? mem_arr[bus.mem_addr] : '0;
        rpipe1 <= rpipe0;
    end

    assign bus.mem_rdata = rpipe1;
    always_comb bus.wr_data = data_of(cyc);

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          flag;
    } exp_t;

    exp_t          q_gnt[$];
    exp_t          q_acc[$];
    exp_t          q_rdv[$];
    int            q_done[$];
    logic [DW-1:0] model [int];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    endtask

    task automatic unexpected(input string name);
        n_total++;
        $display("FAIL %s cycle=%0d got=event want=none", name, cyc);
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.wr_gnt, bus.wr_beat, bus.wr_done, bus.rd_gnt, bus.rd_valid,
                    bus.rd_done, bus.mem_en, bus.mem_rw, bus.busy, bus.mem_addr, bus.rd_data});
    endfunction

    task automatic push_write(input int g, input int a, input int l);
        exp_t e;
        e.cyc = g; e.addr = '0; e.data = '0; e.flag = 1'b0;
        q_gnt.push_back(e);
        for (int i = 0; i <= l; i++) begin
            e.cyc  = g + i;
            e.addr = AW'((a + i) % DEPTH);
            e.data = data_of(g + i);
            e.flag = 1'b1;
            q_acc.push_back(e);
            model[(a + i) % DEPTH] = e.data;
        end
        q_done.push_back(g + l + 1);
    endtask

    task automatic push_read(input int g, input int a, input int l, input int n_iss, input int n_vld);
        exp_t e;
        int   ad;
        e.cyc = g; e.addr = '0; e.data = '0; e.flag = 1'b1;
        q_gnt.push_back(e);
        for (int i = 0; i < n_iss; i++) begin
            e.cyc = g + i; e.addr = AW'((a + i) % DEPTH); e.data = '0; e.flag = 1'b0;
            q_acc.push_back(e);
        end
        for (int i = 0; i < n_vld; i++) begin
            ad     = (a + i) % DEPTH;
            e.cyc  = g + i + RD_LAT;
            e.addr = AW'(ad);
            e.data = model.exists(ad) ? model[ad] : init_val(ad);
            e.flag = (i == l);
            q_rdv.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.wr_gnt || bus.rd_gnt) begin
            if (q_gnt.size() == 0) unexpected("gnt");
            else begin
                e = q_gnt.pop_front();
                chk("gnt_cycle", 64'(cyc), 64'(e.cyc));
                chk("gnt_rd", 64'(bus.rd_gnt), 64'(e.flag));
                chk("gnt_wr", 64'(bus.wr_gnt), 64'(!e.flag));
            end
        end
        if (bus.mem_en) begin
            if (q_acc.size() == 0) unexpected("mem_access");
            else begin
                e = q_acc.pop_front();
                chk("acc_cycle", 64'(cyc), 64'(e.cyc));
                chk("acc_rw", 64'(bus.mem_rw), 64'(e.flag));
                chk("acc_addr", 64'(bus.mem_addr), 64'(e.addr));
                chk("acc_wr_beat", 64'(bus.wr_beat), 64'(e.flag));
                if (e.flag) chk("acc_wdata", 64'(bus.mem_wdata), 64'(e.data));
            end
        end else if (bus.wr_beat) begin
            unexpected("wr_beat_without_mem_en");
        end
        if (bus.rd_valid) begin
            if (q_rdv.size() == 0) unexpected("rd_valid");
            else begin
                e = q_rdv.pop_front();
                chk("rdv_cycle", 64'(cyc), 64'(e.cyc));
                chk("rd_data", 64'(bus.rd_data), 64'(e.data));
                chk("rd_done", 64'(bus.rd_done), 64'(e.flag));
            end
        end else if (bus.rd_done) begin
            unexpected("rd_done_without_valid");
        end
        if (bus.wr_done) begin
            if (q_done.size() == 0) unexpected("wr_done");
            else begin
                chk("wr_done_cycle", 64'(cyc), 64'(q_done.pop_front()));
                chk("busy_after_wr", 64'(bus.busy), 64'd0);
            end
        end
    end

    task automatic wait_empty();
        for (int k = 0; k < 2000; k++) begin
            if (q_gnt.size() + q_acc.size() + q_rdv.size() + q_done.size() == 0) break;
            @(negedge clk);
        end
        chk("scoreboard_drained", 64'(q_gnt.size() + q_acc.size() + q_rdv.size() + q_done.size()), 64'd0);
    endtask

    task automatic run(input bit do_wr, input int wa, input int wl,
                       input bit do_rd, input int ra, input int rl, input bit wr_first);
        int t;
        int k;
        @(posedge clk); #1;
        t = cyc;
        bus.wr_addr = AW'(wa); bus.wr_len = LW'(wl);
        bus.rd_addr = AW'(ra); bus.rd_len = LW'(rl);
        bus.wr_req = do_wr;    bus.rd_req = do_rd;
        if (do_wr && do_rd) begin
            if (wr_first) begin
                push_write(t + 1, wa, wl);
                push_read(t + wl + 3, ra, rl, rl + 1, rl + 1);
            end else begin
                push_read(t + 1, ra, rl, rl + 1, rl + 1);
                push_write(t + rl + RD_LAT + 3, wa, wl);
            end
        end else if (do_wr) begin
            push_write(t + 1, wa, wl);
        end else if (do_rd) begin
            push_read(t + 1, ra, rl, rl + 1, rl + 1);
        end
        k = 0;
        while ((bus.wr_req || bus.rd_req) && k < 1000) begin
            @(negedge clk);
            if (bus.wr_gnt) bus.wr_req = 1'b0;
            if (bus.rd_gnt) bus.rd_req = 1'b0;
            k++;
        end
        chk("req_granted", 64'({bus.wr_req, bus.rd_req}), 64'd0);
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        wait_empty();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_len = '0;
        bus.rd_req = 1'b0; bus.rd_addr = '0; bus.rd_len = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", outs(), 64'd0);
`ifdef MEM1_ARB_STATS_EN
        chk("reset_stats", 64'({stat_wr_bursts, stat_rd_bursts, stat_conflicts}), 64'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        run(1, 'h0010, 3,   0, 0, 0,        0);
        run(0, 0, 0,        1, 'h0010, 3,   0);
        run(0, 0, 0,        1, 'h0100, 0,   0);
        run(1, 'h0200, 2,   1, 'h0200, 2,   1);
        run(1, 'h0300, 1,   0, 0, 0,        0);
        run(1, 'h0400, 0,   1, 'h0300, 1,   0);
        run(1, 'h3FFE, 3,   0, 0, 0,        0);
        run(0, 0, 0,        1, 'h3FFE, 3,   0);
        run(1, 'h1000, 255, 0, 0, 0,        0);
`ifdef MEM1_ARB_STATS_EN
        chk("stat_wr_bursts", 64'(stat_wr_bursts), 64'd6);
        chk("stat_rd_bursts", 64'(stat_rd_bursts), 64'd5);
        chk("stat_conflicts", 64'(stat_conflicts), 64'd2);
`endif

        // Reset lands on the third issue of an 8-beat read
        @(posedge clk); #1;
        t = cyc;
        bus.rd_addr = AW'('h2000); bus.rd_len = LW'(7); bus.rd_req = 1'b1;
        push_read(t + 1, 'h2000, 7, 3, 1);
        @(posedge clk); #1;
        bus.rd_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_burst_reset_outputs", outs(), 64'd0);
        chk("mid_burst_reset_cycle", 64'(cyc), 64'(t + 4));
`ifdef MEM1_ARB_STATS_EN
        chk("mid_burst_reset_stats", 64'({stat_wr_bursts, stat_rd_bursts, stat_conflicts}), 64'd0);
`endif
        repeat (8) @(negedge clk);
        wait_empty();

        run(1, 'h0050, 0,   1, 'h0060, 0,   1);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
